// File: rtl/rr_pkt_arb.sv
// rr_pkt_arb: packet-locking round-robin arbiter with beat-count forced release
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   i_clr         synchronous clear, same effect as reset
//   i_req, i_eop  per-requester request level and end-of-packet flag
//   i_stall       downstream back-pressure; no beat is accepted while high
//   o_grant       registered one-hot owner, zero when idle
//   o_grant_id    registered owner index, zero when idle
//   o_grant_vld   registered, high while an owner exists
//   o_timeout     registered single-cycle pulse on a forced release
module rr_pkt_arb #(
  parameter int NUM_PORT     = 4,
  parameter int LOG_NUM_PORT = 2,
  parameter int MAX_HOLD     = 64,
  parameter int LOG_MAX_HOLD = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clr,
  input  logic [NUM_PORT-1:0]     i_req,
  input  logic [NUM_PORT-1:0]     i_eop,
  input  logic                    i_stall,
  output logic [NUM_PORT-1:0]     o_grant,
  output logic [LOG_NUM_PORT-1:0] o_grant_id,
  output logic                    o_grant_vld,
  output logic                    o_timeout
);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t r_state, w_state_nxt;
  logic [LOG_NUM_PORT-1:0] r_ptr, w_ptr_nxt, w_own_inc, w_sel_id, w_gid_nxt;
  logic [LOG_MAX_HOLD-1:0] r_cnt, w_cnt_nxt;
  logic [NUM_PORT-1:0]     w_grant_nxt;
  logic                    w_acc, w_abort, w_eop_rel, w_to_rel, w_rel, w_load, w_any;
  logic                    w_vld_nxt, w_to_nxt;
  // First set bit of v scanning p, p+1, ... modulo NUM_PORT; returns {found, index}.
  // The downward scan lets the smallest offset from p overwrite the others.
  function automatic logic [LOG_NUM_PORT:0] pick(input logic [NUM_PORT-1:0] v,
                                                 input logic [LOG_NUM_PORT-1:0] p);
    int k;
    pick = '0;
    for (int i = NUM_PORT - 1; i >= 0; i--) begin
      k = int'(p) + i;
      if (k >= NUM_PORT) k = k - NUM_PORT;
      if (v[k]) pick = {1'b1, LOG_NUM_PORT'(k)};
    end
  endfunction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_cnt       <= '0;
      o_grant     <= '0;
      o_grant_id  <= '0;
      o_grant_vld <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
      o_grant     <= w_grant_nxt;
      o_grant_id  <= w_gid_nxt;
      o_grant_vld <= w_vld_nxt;
      o_timeout   <= w_to_nxt;
    end
  end
  // Release detection and the arbitration that feeds both the idle grant and the
  // no-bubble handover; on a release the departing owner is masked out.
  always_comb begin
    w_own_inc = (o_grant_id == LOG_NUM_PORT'(NUM_PORT - 1)) ? '0 : o_grant_id + 1'b1;
    w_acc     = (r_state == LOCK) && !i_stall;
    w_abort   = (r_state == LOCK) && !i_req[o_grant_id];
    w_eop_rel = w_acc && i_eop[o_grant_id];
    w_to_rel  = w_acc && !i_eop[o_grant_id] && (r_cnt == LOG_MAX_HOLD'(MAX_HOLD - 1));
    w_rel     = w_abort || w_eop_rel || w_to_rel;
    w_load    = (r_state == IDLE) || w_rel;
    {w_any, w_sel_id} = pick(w_rel ? (i_req & ~o_grant) : i_req, w_rel ? w_own_inc : r_ptr);
  end
  always_comb begin
    w_state_nxt = i_clr ? IDLE : w_load ? (w_any ? LOCK : IDLE) : r_state;
  end
  always_comb begin
    w_grant_nxt = i_clr ? '0 : w_load ? (w_any ? NUM_PORT'(1) << w_sel_id : '0) : o_grant;
    w_gid_nxt   = i_clr ? '0 : w_load ? (w_any ? w_sel_id : '0) : o_grant_id;
    w_vld_nxt   = i_clr ? 1'b0 : w_load ? w_any : o_grant_vld;
    w_to_nxt    = !i_clr && !w_abort && w_to_rel;
    w_ptr_nxt   = i_clr ? '0 : w_rel ? w_own_inc : r_ptr;
    w_cnt_nxt   = (i_clr || w_load) ? '0 : w_acc ? r_cnt + 1'b1 : r_cnt;
  end
endmodule

// File: tb/tb_rr_pkt_arb.sv
// tb_rr_pkt_arb: scoreboard bench for rr_pkt_arb against a packet-level reference model
module tb_rr_pkt_arb;
  localparam int N  = 4;
  localparam int MH = 8;
  logic       clk = 1'b0;
  logic       rst, clr, stall;
  logic [3:0] req, eop, grant;
  logic [1:0] gid;
  logic       vld, to;
  int         total = 0;
  int         bad = 0;
  int         m_own = -1;
  int         m_ptr = 0;
  int         m_cnt = 0;
  logic [7:0] exp_q[$];
  always #5 clk = ~clk;
  rr_pkt_arb #(.NUM_PORT(N), .LOG_NUM_PORT(2), .MAX_HOLD(MH), .LOG_MAX_HOLD(3)) dut (
    .clk(clk), .rst(rst), .i_clr(clr), .i_req(req), .i_eop(eop), .i_stall(stall),
    .o_grant(grant), .o_grant_id(gid), .o_grant_vld(vld), .o_timeout(to)
  );
  task automatic chk(input string n, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got={grant,id,vld,to}=%h exp=%h", n, $time, got, exp);
    end
  endtask
  function automatic int pick(input logic [3:0] v, input int p);
    for (int i = 0; i < N; i++) if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction
  // One clock edge of the arbiter's packet rules; pushes the outputs expected after it.
  task automatic model(input logic [3:0] r, input logic [3:0] e, input logic s, input logic c);
    logic       t;
    bit         rel;
    logic [3:0] g;
    t = 1'b0;
    rel = 1'b0;
    if (c) begin
      m_own = -1; m_ptr = 0; m_cnt = 0;
    end else if (m_own < 0) begin
      m_own = pick(r, m_ptr); m_cnt = 0;
    end else begin
      if (!r[m_own]) rel = 1'b1;
      else if (!s) begin
        if (e[m_own]) rel = 1'b1;
        else if (m_cnt == MH - 1) begin rel = 1'b1; t = 1'b1; end
        else m_cnt++;
      end
      if (rel) begin
        m_ptr = (m_own + 1) % N;
        g = r & ~(4'b1 << m_own);
        m_own = pick(g, m_ptr);
        m_cnt = 0;
      end
    end
    g = (m_own >= 0) ? 4'(1 << m_own) : 4'b0;
    exp_q.push_back({g, (m_own >= 0) ? 2'(m_own) : 2'd0, m_own >= 0, t});
  endtask
  task automatic cyc(input logic [3:0] r, input logic [3:0] e, input logic s, input logic c);
    req = r; eop = e; stall = s; clr = c;
    @(posedge clk);
    model(r, e, s, c);
    #1;
  endtask
  always @(negedge clk) begin
    logic [7:0] x;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      chk("out", {grant, gid, vld, to}, x);
    end
  end
  initial begin
    logic [3:0] r;
    rst = 1'b1; clr = 1'b0; stall = 1'b0; req = 4'b0100; eop = 4'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst", {grant, gid, vld, to}, 8'h00);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) cyc(4'b0100, 4'b0, 1'b0, 1'b0);
    cyc(4'hf, 4'h0, 1'b0, 1'b1);
    repeat (16) cyc(4'hf, (m_cnt == 2) ? 4'hf : 4'h0, 1'b0, 1'b0);
    cyc(4'b0010, 4'h0, 1'b0, 1'b1);
    cyc(4'b0010, 4'h0, 1'b0, 1'b0);
    cyc(4'b0110, 4'h0, 1'b0, 1'b0);
    repeat (4) cyc(4'b0110, 4'hf, 1'b1, 1'b0);
    cyc(4'b0110, 4'hf, 1'b0, 1'b0);
    cyc(4'b0110, 4'h0, 1'b0, 1'b0);
    cyc(4'b1000, 4'h0, 1'b0, 1'b1);
    cyc(4'b1000, 4'h0, 1'b0, 1'b0);
    repeat (10) cyc(4'b1001, 4'h0, 1'b0, 1'b0);
    cyc(4'b0000, 4'h0, 1'b0, 1'b1);
    repeat (3) cyc(4'b1000, 4'h0, 1'b0, 1'b0);
    repeat (2) cyc(4'b0001, 4'h0, 1'b0, 1'b0);
    cyc(4'b0000, 4'h0, 1'b0, 1'b1);
    cyc(4'b0100, 4'h0, 1'b0, 1'b0);
    cyc(4'b1111, 4'h0, 1'b0, 1'b0);
    cyc(4'b1111, 4'h0, 1'b0, 1'b1);
    repeat (2) cyc(4'b1111, 4'h0, 1'b0, 1'b0);
    r = 4'b0;
    repeat (3000) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
      cyc(r, 4'($urandom) & 4'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
    end
    repeat (2) @(negedge clk);
    chk("drain", 8'(exp_q.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
